// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_pkg
// Description : Shared definitions for the MEM-stage exception controller:
//               exception codes, CP0 register numbers, fault-flag bit
//               positions, FSM state encoding and the Cause-merge helper.
// Revision    : 1.0  initial release
// ============================================================================
package exc_ctrl_pkg;

  // Exception codes written to CP0 (0 means no exception)
  localparam logic [31:0] c_exc_none = 32'h0000_0000;
  localparam logic [31:0] c_exc_int  = 32'h0000_0001;
  localparam logic [31:0] c_exc_adel = 32'h0000_0004;
  localparam logic [31:0] c_exc_ades = 32'h0000_0005;
  localparam logic [31:0] c_exc_sys  = 32'h0000_0008;
  localparam logic [31:0] c_exc_bp   = 32'h0000_0009;
  localparam logic [31:0] c_exc_ri   = 32'h0000_000a;
  localparam logic [31:0] c_exc_ov   = 32'h0000_000c;
  localparam logic [31:0] c_exc_tr   = 32'h0000_000d;
  localparam logic [31:0] c_exc_eret = 32'h0000_000e;

  // CP0 register numbers relevant to exception handling
  localparam logic [4:0] c_cp0_status = 5'd12;
  localparam logic [4:0] c_cp0_cause  = 5'd13;
  localparam logic [4:0] c_cp0_epc    = 5'd14;

  // Bit positions inside exc_flags_i
  localparam int c_flg_eret       = 8;
  localparam int c_flg_fetch_adel = 7;
  localparam int c_flg_ri         = 6;
  localparam int c_flg_syscall    = 5;
  localparam int c_flg_break      = 4;
  localparam int c_flg_ov         = 3;
  localparam int c_flg_trap       = 2;
  localparam int c_flg_data_adel  = 1;
  localparam int c_flg_data_ades  = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // mtc0 to Cause only updates the software-interrupt bits (9:8) and the
  // IV/WP bits (23:22); everything else keeps the register value.
  function automatic logic [31:0] merge_cause(input logic [31:0] cur,
                                              input logic [31:0] wr);
    logic [31:0] res;
    res        = cur;
    res[9:8]   = wr[9:8];
    res[23:22] = wr[23:22];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_if
// Description : Bundle of MEM-stage, CP0 and WB-forwarding inputs plus the
//               CP0 commit / pipeline redirect outputs of exc_ctrl.
//               slave  : exc_ctrl side (consumes inputs, drives outputs)
//               master : pipeline / environment side
// Revision    : 1.0  initial release
// ============================================================================
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic        stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [8:0]  exc_flags_i;
  logic [31:0] fetch_badaddr_i;
  logic [31:0] data_badaddr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] exc_badaddr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport slave (
    input  mem_valid_i, stall_i, mem_pc_i, mem_in_delayslot_i, exc_flags_i,
           fetch_badaddr_i, data_badaddr_i, cp0_status_i, cp0_cause_i,
           cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, exc_pc_o, exc_delayslot_o, exc_badaddr_o, flush_o,
           new_pc_o, busy_o
  );

  modport master (
    output mem_valid_i, stall_i, mem_pc_i, mem_in_delayslot_i, exc_flags_i,
           fetch_badaddr_i, data_badaddr_i, cp0_status_i, cp0_cause_i,
           cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, exc_pc_o, exc_delayslot_o, exc_badaddr_o, flush_o,
           new_pc_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio_enc
// Description : Combinational exception priority encoder. Picks the highest
//               priority pending cause and its bad virtual address.
//   i_int_p          pending enabled interrupt
//   i_flags[8:0]     {eret, fetch_adel, ri, syscall, break, ov, trap,
//                     data_adel, data_ades}
//   i_fetch_badaddr  faulting fetch address
//   i_data_badaddr   faulting load/store address
//   o_code           selected exception code (0 = none)
//   o_badaddr        bad address for address errors, else 0
// Revision    : 1.0  initial release
// ============================================================================
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  wire logic        i_int_p,
  input  wire logic [8:0]  i_flags,
  input  wire logic [31:0] i_fetch_badaddr,
  input  wire logic [31:0] i_data_badaddr,
  output logic      [31:0] o_code,
  output logic      [31:0] o_badaddr
);

  always_comb begin
    o_code    = c_exc_none;
    o_badaddr = 32'h0;
    if (i_int_p) begin
      o_code = c_exc_int;
    end else if (i_flags[c_flg_fetch_adel]) begin
      o_code    = c_exc_adel;
      o_badaddr = i_fetch_badaddr;
    end else if (i_flags[c_flg_ri]) begin
      o_code = c_exc_ri;
    end else if (i_flags[c_flg_syscall]) begin
      o_code = c_exc_sys;
    end else if (i_flags[c_flg_break]) begin
      o_code = c_exc_bp;
    end else if (i_flags[c_flg_ov]) begin
      o_code = c_exc_ov;
    end else if (i_flags[c_flg_trap]) begin
      o_code = c_exc_tr;
    end else if (i_flags[c_flg_data_adel]) begin
      o_code    = c_exc_adel;
      o_badaddr = i_data_badaddr;
    end else if (i_flags[c_flg_data_ades]) begin
      o_code    = c_exc_ades;
      o_badaddr = i_data_badaddr;
    end else if (i_flags[c_flg_eret]) begin
      o_code = c_exc_eret;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : MEM-stage exception arbiter and pipeline redirect unit.
//               Commits one exception per faulting instruction to CP0,
//               flushes the pipeline and redirects to the handler (or EPC
//               for eret), then ignores faults for BLANK_CYCLES cycles while
//               the pipeline refills.
//   clk, rst   clock, synchronous active-high reset
//   bus        exc_ctrl_if.slave: MEM-stage instruction info, CP0 register
//              values, WB mtc0 forwarding inputs; CP0 commit, flush,
//              new_pc and busy outputs (all registered)
// Revision    : 1.0  initial release
// ============================================================================
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          BLANK_CYCLES = 3
) (
  input wire logic  clk,
  input wire logic  rst,
  exc_ctrl_if.slave bus
);

  localparam int c_cnt_w = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_blank_init = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  // Effective CP0 values, with an in-flight WB mtc0 forwarded in
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_int_p;
  logic [31:0] w_code;
  logic [31:0] w_badaddr;
  logic        w_accept;

  always_comb begin
    w_status = bus.cp0_status_i;
    w_cause  = bus.cp0_cause_i;
    w_epc    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == c_cp0_status) w_status = bus.wb_cp0_data_i;
      if (bus.wb_cp0_waddr_i == c_cp0_cause)
        w_cause = merge_cause(bus.cp0_cause_i, bus.wb_cp0_data_i);
      if (bus.wb_cp0_waddr_i == c_cp0_epc) w_epc = bus.wb_cp0_data_i;
    end
  end

  // IE set, EXL clear, and at least one unmasked pending interrupt line
  assign w_int_p = w_status[0] & ~w_status[1] &
                   (|(w_cause[15:8] & w_status[15:8]));

  exc_prio_enc u_prio_enc (
    .i_int_p         (w_int_p),
    .i_flags         (bus.exc_flags_i),
    .i_fetch_badaddr (bus.fetch_badaddr_i),
    .i_data_badaddr  (bus.data_badaddr_i),
    .o_code          (w_code),
    .o_badaddr       (w_badaddr)
  );

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_excepttype;
  logic [31:0]        r_exc_pc;
  logic               r_exc_delayslot;
  logic [31:0]        r_exc_badaddr;
  logic               r_flush;
  logic [31:0]        r_new_pc;

  assign w_accept = (r_state == ST_IDLE) & bus.mem_valid_i & ~bus.stall_i &
                    (w_code != c_exc_none);

  // Commit outputs are one-cycle pulses: cleared every cycle unless a new
  // exception is accepted on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_excepttype    <= 32'h0;
      r_exc_pc        <= 32'h0;
      r_exc_delayslot <= 1'b0;
      r_exc_badaddr   <= 32'h0;
      r_flush         <= 1'b0;
      r_new_pc        <= 32'h0;
    end else begin
      r_excepttype    <= 32'h0;
      r_exc_pc        <= 32'h0;
      r_exc_delayslot <= 1'b0;
      r_exc_badaddr   <= 32'h0;
      r_flush         <= 1'b0;
      r_new_pc        <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_excepttype    <= w_code;
            r_exc_pc        <= bus.mem_pc_i;
            r_exc_delayslot <= bus.mem_in_delayslot_i;
            r_exc_badaddr   <= w_badaddr;
            r_flush         <= 1'b1;
            r_new_pc        <= (w_code == c_exc_eret) ? w_epc : EXC_VECTOR;
            if (BLANK_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_BLANK;
              r_cnt   <= c_blank_init;
            end
          end
        end
        ST_BLANK: begin
          // Faults arriving here belong to instructions being flushed
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt <= c_cnt_one) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.excepttype_o    = r_excepttype;
  assign bus.exc_pc_o        = r_exc_pc;
  assign bus.exc_delayslot_o = r_exc_delayslot;
  assign bus.exc_badaddr_o   = r_exc_badaddr;
  assign bus.flush_o         = r_flush;
  assign bus.new_pc_o        = r_new_pc;
  assign bus.busy_o          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Directed self-checking bench for exc_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_exc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  exc_ctrl_if u_if ();

  exc_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .BLANK_CYCLES (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.mem_valid_i        = 1'b0;
    u_if.stall_i            = 1'b0;
    u_if.mem_pc_i           = 32'h0;
    u_if.mem_in_delayslot_i = 1'b0;
    u_if.exc_flags_i        = 9'h0;
    u_if.fetch_badaddr_i    = 32'h0;
    u_if.data_badaddr_i     = 32'h0;
    u_if.cp0_status_i       = 32'h0;
    u_if.cp0_cause_i        = 32'h0;
    u_if.cp0_epc_i          = 32'h0;
    u_if.wb_cp0_we_i        = 1'b0;
    u_if.wb_cp0_waddr_i     = 5'h0;
    u_if.wb_cp0_data_i      = 32'h0;
  endtask

  task automatic present(input logic [31:0] pc, input logic ds,
                         input logic [8:0] flags);
    u_if.mem_valid_i        = 1'b1;
    u_if.mem_pc_i           = pc;
    u_if.mem_in_delayslot_i = ds;
    u_if.exc_flags_i        = flags;
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_code"},  u_if.excepttype_o, 32'h0);
    check({tag, "_flush"}, {31'h0, u_if.flush_o}, 32'h0);
  endtask

  task automatic expect_commit(input string tag, input logic [31:0] code,
                               input logic [31:0] pc, input logic ds,
                               input logic [31:0] bad, input logic [31:0] npc);
    check({tag, "_code"},  u_if.excepttype_o, code);
    check({tag, "_pc"},    u_if.exc_pc_o, pc);
    check({tag, "_ds"},    {31'h0, u_if.exc_delayslot_o}, {31'h0, ds});
    check({tag, "_bad"},   u_if.exc_badaddr_o, bad);
    check({tag, "_flush"}, {31'h0, u_if.flush_o}, 32'h1);
    check({tag, "_npc"},   u_if.new_pc_o, npc);
    check({tag, "_busy"},  {31'h0, u_if.busy_o}, 32'h1);
  endtask

  // Clear inputs and run out the three refill cycles
  task automatic settle(input string tag);
    clear_inputs();
    repeat (3) tick();
    check({tag, "_idle"}, {31'h0, u_if.busy_o}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    expect_quiet("reset");
    check("reset_pc",   u_if.exc_pc_o, 32'h0);
    check("reset_npc",  u_if.new_pc_o, 32'h0);
    check("reset_busy", {31'h0, u_if.busy_o}, 32'h0);
    rst = 1'b0;
    tick();

    // syscall, then the same fault held through the refill window
    present(32'h100, 1'b0, 9'h020);
    tick();
    expect_commit("sys", 32'h08, 32'h100, 1'b0, 32'h0, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_quiet("sys_blank");
      check("sys_blank_busy", {31'h0, u_if.busy_o}, (i < 2) ? 32'h1 : 32'h0);
    end
    clear_inputs();
    tick();
    expect_quiet("sys_after");

    // ov outranks data_ades; no bad address for ov
    present(32'h204, 1'b1, 9'h009);
    u_if.data_badaddr_i = 32'hdead_beef;
    tick();
    expect_commit("ov", 32'h0c, 32'h204, 1'b1, 32'h0, 32'h20);
    settle("ov");

    // fetch_adel outranks data_adel and carries the fetch address
    present(32'h300, 1'b0, 9'h082);
    u_if.fetch_badaddr_i = 32'h0000_1001;
    u_if.data_badaddr_i  = 32'h0000_2002;
    tick();
    expect_commit("fadel", 32'h04, 32'h300, 1'b0, 32'h1001, 32'h20);
    settle("fadel");

    present(32'h304, 1'b0, 9'h001);
    u_if.data_badaddr_i = 32'h0000_2003;
    tick();
    expect_commit("ades", 32'h05, 32'h304, 1'b0, 32'h2003, 32'h20);
    settle("ades");

    // interrupt from Status/Cause registers
    present(32'h400, 1'b0, 9'h000);
    u_if.cp0_status_i = 32'h0000_0401;
    u_if.cp0_cause_i  = 32'h0000_0400;
    tick();
    expect_commit("int", 32'h01, 32'h400, 1'b0, 32'h0, 32'h20);
    settle("int");

    // same, but WB mtc0 sets EXL -> masked
    present(32'h400, 1'b0, 9'h000);
    u_if.cp0_status_i  = 32'h0000_0401;
    u_if.cp0_cause_i   = 32'h0000_0400;
    u_if.wb_cp0_we_i   = 1'b1;
    u_if.wb_cp0_waddr_i = 5'd12;
    u_if.wb_cp0_data_i = 32'h0000_0403;
    tick();
    expect_quiet("int_exl");
    check("int_exl_busy", {31'h0, u_if.busy_o}, 32'h0);
    clear_inputs();

    // forwarded software interrupt bit 8 in Cause
    present(32'h408, 1'b0, 9'h000);
    u_if.cp0_status_i   = 32'h0000_0101;
    u_if.wb_cp0_we_i    = 1'b1;
    u_if.wb_cp0_waddr_i = 5'd13;
    u_if.wb_cp0_data_i  = 32'h0000_0100;
    tick();
    expect_commit("swint", 32'h01, 32'h408, 1'b0, 32'h0, 32'h20);
    settle("swint");

    // mtc0 Cause cannot set hardware bit 10
    present(32'h40c, 1'b0, 9'h000);
    u_if.cp0_status_i   = 32'h0000_0401;
    u_if.wb_cp0_we_i    = 1'b1;
    u_if.wb_cp0_waddr_i = 5'd13;
    u_if.wb_cp0_data_i  = 32'h0000_0400;
    tick();
    expect_quiet("hwbit_fwd");
    clear_inputs();

    // pending interrupt with a bubble in MEM
    u_if.cp0_status_i = 32'h0000_0401;
    u_if.cp0_cause_i  = 32'h0000_0400;
    tick();
    expect_quiet("int_bubble");
    clear_inputs();

    // eret with forwarded EPC
    present(32'h500, 1'b0, 9'h100);
    u_if.cp0_epc_i      = 32'h0000_0040;
    u_if.wb_cp0_we_i    = 1'b1;
    u_if.wb_cp0_waddr_i = 5'd14;
    u_if.wb_cp0_data_i  = 32'h0000_0080;
    tick();
    expect_commit("eret_fwd", 32'h0e, 32'h500, 1'b0, 32'h0, 32'h80);
    settle("eret_fwd");

    present(32'h504, 1'b0, 9'h100);
    u_if.cp0_epc_i = 32'h0000_0044;
    tick();
    expect_commit("eret", 32'h0e, 32'h504, 1'b0, 32'h0, 32'h44);
    settle("eret");

    // ri right after a flush is discarded, later ri is committed
    present(32'h600, 1'b0, 9'h020);
    tick();
    expect_commit("sys2", 32'h08, 32'h600, 1'b0, 32'h0, 32'h20);
    present(32'h604, 1'b0, 9'h040);
    tick();
    expect_quiet("ri_blank");
    clear_inputs();
    tick();
    tick();
    check("ri_idle", {31'h0, u_if.busy_o}, 32'h0);
    present(32'h608, 1'b0, 9'h040);
    tick();
    expect_commit("ri", 32'h0a, 32'h608, 1'b0, 32'h0, 32'h20);
    settle("ri");

    // break held under a two-cycle stall
    present(32'h700, 1'b0, 9'h010);
    u_if.stall_i = 1'b1;
    tick();
    expect_quiet("stall1");
    tick();
    expect_quiet("stall2");
    u_if.stall_i = 1'b0;
    tick();
    expect_commit("brk", 32'h09, 32'h700, 1'b0, 32'h0, 32'h20);

    // reset while in BLANK
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_quiet("rst_blank");
    check("rst_blank_busy", {31'h0, u_if.busy_o}, 32'h0);
    check("rst_blank_npc",  u_if.new_pc_o, 32'h0);

    // reset on the accept edge drops the flush
    present(32'h800, 1'b0, 9'h004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_quiet("rst_accept");
    check("rst_accept_busy", {31'h0, u_if.busy_o}, 32'h0);
    tick();
    expect_commit("trap", 32'h0d, 32'h800, 1'b0, 32'h0, 32'h20);
    settle("trap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
MEM-stage exception arbiter and pipeline redirect unit. It drives the CP0 register file's exception-commit inputs (excepttype, instruction address, delay-slot flag, bad address) and issues the pipeline flush and the handler/EPC redirect.
- Combines per-instruction fault flags, pending hardware/software interrupts, and CP0 status/cause/epc, with those values forwarded from an in-flight WB-stage mtc0.
- Commits exactly one exception per faulting instruction, then masks further commits until the pipeline has refilled.

Parameters:
EXC_VECTOR, 32'h00000020, handler entry PC for all exceptions except eret.
BLANK_CYCLES, 3, cycles after a flush during which no new exception is committed (pipeline refill).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
stall_i  in  1  MEM stage stalled this cycle
mem_pc_i  in  32  PC of MEM-stage instruction
mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
exc_flags_i  in  9  {eret, fetch_adel, ri, syscall, break, ov, trap, data_adel, data_ades}
fetch_badaddr_i  in  32  faulting fetch address
data_badaddr_i  in  32  faulting load/store address
cp0_status_i  in  32  CP0 Status (register output)
cp0_cause_i  in  32  CP0 Cause (register output)
cp0_epc_i  in  32  CP0 EPC (register output)
wb_cp0_we_i  in  1  WB-stage mtc0 write enable
wb_cp0_waddr_i  in  5  WB-stage mtc0 register number
wb_cp0_data_i  in  32  WB-stage mtc0 data
excepttype_o  out  32  exception code to CP0 (0 = none)
exc_pc_o  out  32  instruction address to CP0
exc_delayslot_o  out  1  delay-slot flag to CP0
exc_badaddr_o  out  32  bad virtual address to CP0
flush_o  out  1  flush all pipeline registers
new_pc_o  out  32  redirect target, valid when flush_o=1
busy_o  out  1  high outside IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; blank counter 0.
- Forwarding: if wb_cp0_we_i and waddr = 12/13/14, the effective Status, Cause or EPC is taken from wb_cp0_data_i.
  - Cause forwarding replaces only bits 9:8, 22 and 23.
  - Otherwise the cp0_*_i input is used.
- Interrupt pending (int_p): eff_status[0]=1, eff_status[1]=0, and (eff_cause[15:8] & eff_status[15:8]) != 0.
- Code select, priority high to low:
  - int_p → 0x01
  - fetch_adel → 0x04, badaddr=fetch_badaddr_i
  - ri → 0x0a
  - syscall → 0x08
  - break → 0x09
  - ov → 0x0c
  - trap → 0x0d
  - data_adel → 0x04, badaddr=data_badaddr_i
  - data_ades → 0x05, badaddr=data_badaddr_i
  - eret → 0x0e
  - none → 0
- Accept condition: state==IDLE, mem_valid_i=1, stall_i=0, code!=0.
- States:
  - IDLE: on accept, register excepttype_o, exc_pc_o=mem_pc_i, exc_delayslot_o, exc_badaddr_o (0 when code has no bad address); assert flush_o; new_pc_o = effective EPC if code=0x0e, else EXC_VECTOR. Next state is BLANK, with counter = BLANK_CYCLES. With no accept, outputs stay 0.
  - The registered outputs appear for exactly one cycle (the cycle after accept). CP0 captures them on the following edge.
  - BLANK: excepttype_o=0, flush_o=0. Counter decrements each cycle; returns to IDLE when counter==1. Accept is ignored, and a faulting instruction in BLANK is discarded without commit. BLANK_CYCLES=0 returns to IDLE directly.
- busy_o = (state != IDLE).
- Simultaneous WB mtc0 to EPC and eret in MEM: new_pc_o uses the forwarded data.
- Stall: while stall_i=1 nothing is committed; the exception is evaluated again when the stall clears.
- rst asserted in any state: next cycle is IDLE with all outputs 0; a pending flush is dropped.

Decomposition:
- Shared defines file (existing): exception codes 0x01, 0x04, 0x05, 0x08, 0x09, 0x0a, 0x0c, 0x0d, 0x0e; CP0 register numbers; state encodings; flag bit indices.
- One sub-module, exc_prio_enc: combinational priority encoder from {int_p, flags, badaddrs} to {code, badaddr}.
- Forwarding and FSM logic stay in exc_ctrl.

Test Plan:
- syscall at pc=0x100, not in delay slot → next cycle: excepttype_o=0x08, exc_pc_o=0x100, flush_o=1, new_pc_o=0x20; following 3 cycles: no commit.
- ov and data_ades together, in delay slot, pc=0x204 → excepttype_o=0x0c, exc_delayslot_o=1, exc_badaddr_o=0.
- Status=0x0000_0401, cause[10]=1, any valid instruction → code 0x01. Same stimulus with WB mtc0 Status=0x0000_0403 in the same cycle → no exception.
- eret with cp0_epc_i=0x40 while WB mtc0 EPC=0x80 → new_pc_o=0x80, excepttype_o=0x0e.
- Second fault (ri) one cycle after a flush → ignored, no excepttype_o; ri after BLANK expires → committed with code 0x0a.
- Fault with stall_i=1 for 2 cycles → no output until the stall drops, then a single commit. rst in BLANK → IDLE, outputs 0.
